// File: rtl/des_arbiter.sv
// Two-requester round-robin front end for a single DES core.
// Optional grant counters: define DES_ARB_PERF_CNT_EN.
module des_arbiter #(
  parameter int TAG_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [63:0] req_key_0,
  input  logic [63:0] req_key_1,
  input  logic [63:0] req_text_0,
  input  logic [63:0] req_text_1,
  input  logic        req_enc_0,
  input  logic        req_enc_1,
  output logic        resp_valid_0,
  output logic        resp_valid_1,
  output logic [63:0] resp_data_0,
  output logic [63:0] resp_data_1,
  output logic        des_valid_in,
  output logic [63:0] des_cipher_key,
  output logic [63:0] des_plain_text,
  output logic        des_encrypt_decrypt,
  input  logic [63:0] des_cipher_text,
  input  logic        des_valid_out,
  output logic [6:0]  outstanding,
  output logic        err_orphan,
  output logic [15:0] grant_cnt_0,
  output logic [15:0] grant_cnt_1
);

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [6:0] DEPTH = 7'(TAG_DEPTH);

  logic          last_grant;
  logic [6:0]    count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          tag_q [TAG_DEPTH];

  logic full;
  logic gnt_0;
  logic gnt_1;
  logic push;
  logic push_id;
  logic pop;
  logic pop_id;
  logic orphan;

  // Grant, push and pop decisions; full uses the pre-pop count.
  always_comb begin
    full    = (count == DEPTH);
    gnt_0   = rstn && !full && req_valid_0
              && (!req_valid_1 || last_grant);
    gnt_1   = rstn && !full && req_valid_1
              && (!req_valid_0 || !last_grant);
    push    = gnt_0 || gnt_1;
    push_id = gnt_1;
    pop     = des_valid_out && (count != 7'd0);
    orphan  = des_valid_out && (count == 7'd0);
    pop_id  = tag_q[rd_ptr];
  end

  assign req_ready_0 = gnt_0;
  assign req_ready_1 = gnt_1;
  assign outstanding = count;

  // Register the winner's operands and strobe the core for one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      des_valid_in        <= 1'b0;
      des_cipher_key      <= '0;
      des_plain_text      <= '0;
      des_encrypt_decrypt <= 1'b0;
      last_grant          <= 1'b1;
    end else begin
      des_valid_in <= push;
      if (push) begin
        last_grant          <= push_id;
        des_cipher_key      <= push_id ? req_key_1  : req_key_0;
        des_plain_text      <= push_id ? req_text_1 : req_text_0;
        des_encrypt_decrypt <= push_id ? req_enc_1  : req_enc_0;
      end
    end
  end

  // Tag storage; contents are meaningless outside [rd_ptr, wr_ptr).
  always_ff @(posedge clk) begin
    if (push)
      tag_q[wr_ptr] <= push_id;
  end

  // Pointers and occupancy; pointers wrap naturally at TAG_DEPTH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + 7'd1;
        2'b01:   count <= count - 7'd1;
        default: count <= count;
      endcase
    end
  end

  // Route each result to the requester at the head of the tag queue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_valid_0 <= 1'b0;
      resp_valid_1 <= 1'b0;
      resp_data_0  <= '0;
      resp_data_1  <= '0;
      err_orphan   <= 1'b0;
    end else begin
      resp_valid_0 <= pop && !pop_id;
      resp_valid_1 <= pop && pop_id;
      if (pop && !pop_id)
        resp_data_0 <= des_cipher_text;
      if (pop && pop_id)
        resp_data_1 <= des_cipher_text;
      if (orphan)
        err_orphan <= 1'b1;
    end
  end

`ifdef DES_ARB_PERF_CNT_EN
  logic [15:0] cnt_0;
  logic [15:0] cnt_1;

  // Saturating per-requester grant counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_0 <= '0;
      cnt_1 <= '0;
    end else begin
      if (gnt_0 && cnt_0 != 16'hFFFF)
        cnt_0 <= cnt_0 + 16'd1;
      if (gnt_1 && cnt_1 != 16'hFFFF)
        cnt_1 <= cnt_1 + 16'd1;
    end
  end

  assign grant_cnt_0 = cnt_0;
  assign grant_cnt_1 = cnt_1;
`else
  assign grant_cnt_0 = '0;
  assign grant_cnt_1 = '0;
`endif

endmodule

// File: tb/tb_des_arbiter.sv
// Directed bench for des_arbiter.
// Inputs change on falling edges; outputs sampled there too.
module tb_des_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [63:0] req_key_0, req_key_1;
  logic [63:0] req_text_0, req_text_1;
  logic        req_enc_0, req_enc_1;
  logic        resp_valid_0, resp_valid_1;
  logic [63:0] resp_data_0, resp_data_1;
  logic        des_valid_in;
  logic [63:0] des_cipher_key, des_plain_text;
  logic        des_encrypt_decrypt;
  logic [63:0] des_cipher_text;
  logic        des_valid_out;
  logic [6:0]  outstanding;
  logic        err_orphan;
  logic [15:0] grant_cnt_0, grant_cnt_1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  des_arbiter #(.TAG_DEPTH(16)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_key_0(req_key_0), .req_key_1(req_key_1),
    .req_text_0(req_text_0), .req_text_1(req_text_1),
    .req_enc_0(req_enc_0), .req_enc_1(req_enc_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_data_0(resp_data_0), .resp_data_1(resp_data_1),
    .des_valid_in(des_valid_in),
    .des_cipher_key(des_cipher_key),
    .des_plain_text(des_plain_text),
    .des_encrypt_decrypt(des_encrypt_decrypt),
    .des_cipher_text(des_cipher_text),
    .des_valid_out(des_valid_out),
    .outstanding(outstanding), .err_orphan(err_orphan),
    .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1)
  );

  task automatic idle_inputs();
    req_valid_0 = 0; req_valid_1 = 0;
    req_key_0 = 0; req_key_1 = 0;
    req_text_0 = 0; req_text_1 = 0;
    req_enc_0 = 0; req_enc_1 = 0;
    des_cipher_text = 0; des_valid_out = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    req_valid_0 = 1;
    req_valid_1 = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready_0, req_ready_1} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=00",
               {req_ready_0, req_ready_1});
    end
    checks++;
    if ({des_valid_in, resp_valid_0, resp_valid_1, err_orphan}
        !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000",
               {des_valid_in, resp_valid_0, resp_valid_1, err_orphan});
    end
    checks++;
    if (des_cipher_key !== 64'd0 || resp_data_0 !== 64'd0
        || outstanding !== 7'd0 || grant_cnt_0 !== 16'd0) begin
      failures++;
      $display("FAIL reset_regs key=%h rd0=%h out=%0d gc0=%0d exp=0",
               des_cipher_key, resp_data_0, outstanding, grant_cnt_0);
    end
    req_valid_0 = 0;
    req_valid_1 = 0;
    rstn = 1;
    @(negedge clk);
    checks++;
    if (des_valid_in !== 1'b0 || outstanding !== 7'd0) begin
      failures++;
      $display("FAIL post_reset dvi=%b out=%0d exp=0 0",
               des_valid_in, outstanding);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_valid_0 = 1;
    req_key_0 = 64'h133457799BBCDFF1;
    req_text_0 = 64'h0123456789ABCDEF;
    req_enc_0 = 1;
    #1;
    checks++;
    if ({req_ready_0, req_ready_1} !== 2'b10) begin
      failures++;
      $display("FAIL single_ready got=%b exp=10",
               {req_ready_0, req_ready_1});
    end
    @(negedge clk);
    req_valid_0 = 0;
    req_key_0 = 64'hDEAD;
    checks++;
    if (des_valid_in !== 1'b1 || des_encrypt_decrypt !== 1'b1
        || des_cipher_key !== 64'h133457799BBCDFF1
        || des_plain_text !== 64'h0123456789ABCDEF) begin
      failures++;
      $display("FAIL single_issue dvi=%b enc=%b key=%h txt=%h",
               des_valid_in, des_encrypt_decrypt,
               des_cipher_key, des_plain_text);
    end
    @(negedge clk);
    checks++;
    if (des_valid_in !== 1'b0
        || des_cipher_key !== 64'h133457799BBCDFF1
        || outstanding !== 7'd1) begin
      failures++;
      $display("FAIL single_hold dvi=%b key=%h out=%0d",
               des_valid_in, des_cipher_key, outstanding);
    end
    des_valid_out = 1;
    des_cipher_text = 64'h85E813540F0AB405;
    @(negedge clk);
    des_valid_out = 0;
    des_cipher_text = 64'h0;
    checks++;
    if (resp_valid_0 !== 1'b1 || resp_valid_1 !== 1'b0
        || resp_data_0 !== 64'h85E813540F0AB405
        || outstanding !== 7'd0) begin
      failures++;
      $display("FAIL single_resp v0=%b v1=%b d0=%h out=%0d",
               resp_valid_0, resp_valid_1, resp_data_0, outstanding);
    end
    @(negedge clk);
    checks++;
    if (resp_valid_0 !== 1'b0
        || resp_data_0 !== 64'h85E813540F0AB405) begin
      failures++;
      $display("FAIL single_resp_hold v0=%b d0=%h",
               resp_valid_0, resp_data_0);
    end
  endtask

  task automatic test_contention();
    logic [15:0] exp_cnt;
    apply_reset();
    req_key_0 = 64'hAAAA0000AAAA0000;
    req_key_1 = 64'hBBBB1111BBBB1111;
    req_valid_0 = 1;
    req_valid_1 = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if ({req_ready_0, req_ready_1}
          !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL contention_grant%0d got=%b", i,
                 {req_ready_0, req_ready_1});
      end
      @(negedge clk);
      checks++;
      if (des_valid_in !== 1'b1 || des_cipher_key
          !== ((i % 2 == 0) ? 64'hAAAA0000AAAA0000
                            : 64'hBBBB1111BBBB1111)) begin
        failures++;
        $display("FAIL contention_issue%0d dvi=%b key=%h", i,
                 des_valid_in, des_cipher_key);
      end
    end
    req_valid_0 = 0;
    req_valid_1 = 0;
`ifdef DES_ARB_PERF_CNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    checks++;
    if (outstanding !== 7'd6 || grant_cnt_0 !== exp_cnt
        || grant_cnt_1 !== exp_cnt) begin
      failures++;
      $display("FAIL contention_cnt out=%0d gc0=%0d gc1=%0d exp=6 %0d",
               outstanding, grant_cnt_0, grant_cnt_1, exp_cnt);
    end
  endtask

  task automatic test_full();
    apply_reset();
    req_valid_0 = 1;
    repeat (16) @(negedge clk);
    req_valid_1 = 1;
    #1;
    checks++;
    if (outstanding !== 7'd16
        || {req_ready_0, req_ready_1} !== 2'b00) begin
      failures++;
      $display("FAIL full_stall out=%0d rdy=%b exp=16 00",
               outstanding, {req_ready_0, req_ready_1});
    end
    des_valid_out = 1;
    des_cipher_text = 64'h5555;
    #1;
    checks++;
    if ({req_ready_0, req_ready_1} !== 2'b00) begin
      failures++;
      $display("FAIL full_prepop rdy=%b exp=00",
               {req_ready_0, req_ready_1});
    end
    @(negedge clk);
    des_valid_out = 0;
    #1;
    checks++;
    if (outstanding !== 7'd15
        || {req_ready_0, req_ready_1} !== 2'b01
        || resp_valid_0 !== 1'b1) begin
      failures++;
      $display("FAIL full_release out=%0d rdy=%b rv0=%b exp=15 01 1",
               outstanding, {req_ready_0, req_ready_1}, resp_valid_0);
    end
    req_valid_0 = 0;
    req_valid_1 = 0;
  endtask

  task automatic test_ordering();
    logic [3:0]  tags;
    logic [63:0] res [4];
    tags = 4'b0110;
    res[0] = 64'hA; res[1] = 64'hB;
    res[2] = 64'hC; res[3] = 64'hD;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid_0 = !tags[i];
      req_valid_1 = tags[i];
      @(negedge clk);
    end
    req_valid_0 = 0;
    req_valid_1 = 0;
    checks++;
    if (outstanding !== 7'd4) begin
      failures++;
      $display("FAIL order_out got=%0d exp=4", outstanding);
    end
    for (int i = 0; i < 4; i++) begin
      des_valid_out = 1;
      des_cipher_text = res[i];
      @(negedge clk);
      checks++;
      if ({resp_valid_0, resp_valid_1}
          !== (tags[i] ? 2'b01 : 2'b10)
          || (tags[i] ? resp_data_1 : resp_data_0) !== res[i]) begin
        failures++;
        $display("FAIL order_resp%0d v=%b d0=%h d1=%h exp=%h", i,
                 {resp_valid_0, resp_valid_1},
                 resp_data_0, resp_data_1, res[i]);
      end
    end
    des_valid_out = 0;
  endtask

  task automatic test_orphan_reset();
    des_valid_out = 1;
    des_cipher_text = 64'h0BAD;
    @(negedge clk);
    des_valid_out = 0;
    checks++;
    if (err_orphan !== 1'b1 || resp_valid_0 !== 1'b0
        || resp_valid_1 !== 1'b0 || outstanding !== 7'd0) begin
      failures++;
      $display("FAIL orphan eo=%b rv=%b%b out=%0d exp=1 00 0",
               err_orphan, resp_valid_0, resp_valid_1, outstanding);
    end
    req_valid_0 = 1;
    repeat (5) @(negedge clk);
    req_valid_0 = 0;
    checks++;
    if (outstanding !== 7'd5 || err_orphan !== 1'b1) begin
      failures++;
      $display("FAIL orphan_sticky out=%0d eo=%b exp=5 1",
               outstanding, err_orphan);
    end
    #2;
    rstn = 0;
    #1;
    checks++;
    if (outstanding !== 7'd0 || err_orphan !== 1'b0
        || des_valid_in !== 1'b0) begin
      failures++;
      $display("FAIL async_reset out=%0d eo=%b dvi=%b exp=0 0 0",
               outstanding, err_orphan, des_valid_in);
    end
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
  endtask

  initial begin
    rstn = 0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_ordering();
    test_orphan_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
